// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - saturating 0..SCORE_MAX game score with combo bonus and BCD digits
// Optional high-score tracking is enabled by defining SCORE_HIGH_SCORE_EN.
module score_keeper #(
  parameter int SCORE_MAX    = 99,
  parameter int ENEMY_PTS    = 1,
  parameter int BOSS_PTS     = 5,
  parameter int COMBO_WINDOW = 50_000_000,
  parameter int TIMER_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        game_over,
  input  logic        enemy_hit,
  input  logic        boss_hit,
  output logic [31:0] score,
  output logic [3:0]  score_tens,
  output logic [3:0]  score_ones,
  output logic        saturated,
  output logic        combo_active,
  output logic        playing
`ifdef SCORE_HIGH_SCORE_EN
  ,
  output logic [31:0] high_score,
  output logic        new_record
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_e;

  localparam logic [7:0]         MAX8   = 8'(SCORE_MAX);
  localparam logic [7:0]         ENEMY8 = 8'(ENEMY_PTS);
  localparam logic [7:0]         BOSS8  = 8'(BOSS_PTS);
  localparam logic [TIMER_W-1:0] TLOAD  = TIMER_W'(COMBO_WINDOW - 1);

  state_e             state_q, state_d;
  logic               enemy_q, boss_q;
  logic [7:0]         score_q, score_d;
  logic [3:0]         tens_q, ones_q;
  logic               sat_q, sat_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               combo_q;

  logic               in_play;
  logic               enemy_edge, boss_edge;
  logic [7:0]         add_base, add, sum;
  logic [7:0]         bcd_d;

  // Repeated subtraction is enough because the score never exceeds 99.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [3:0] t;
    logic [7:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= 8'd10) begin
        r = r - 8'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (new_game) state_d = S_PLAY;
      S_PLAY:  if (new_game) state_d = S_PLAY;
               else if (game_over) state_d = S_OVER;
      S_OVER:  if (new_game) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_play    = (state_q == S_PLAY);
  assign enemy_edge = enemy_hit & ~enemy_q & in_play;
  assign boss_edge  = boss_hit & ~boss_q & in_play;
  assign add_base   = (enemy_edge ? ENEMY8 : 8'd0) + (boss_edge ? BOSS8 : 8'd0);
  assign add        = (timer_q != '0) ? (add_base << 1) : add_base;
  assign sum        = score_q + add;

  always_comb begin
    score_d = score_q;
    sat_d   = sat_q;
    timer_d = timer_q;
    if (new_game) begin
      score_d = 8'd0;
      sat_d   = 1'b0;
      timer_d = '0;
    end else if (in_play) begin
      if (enemy_edge || boss_edge) begin
        timer_d = TLOAD;
        if (sum > MAX8) begin
          score_d = MAX8;
          sat_d   = 1'b1;
        end else begin
          score_d = sum;
        end
      end else if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  assign bcd_d = to_bcd(score_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      enemy_q <= 1'b0;
      boss_q  <= 1'b0;
      score_q <= 8'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      sat_q   <= 1'b0;
      timer_q <= '0;
      combo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enemy_q <= enemy_hit;
      boss_q  <= boss_hit;
      score_q <= score_d;
      tens_q  <= bcd_d[7:4];
      ones_q  <= bcd_d[3:0];
      sat_q   <= sat_d;
      timer_q <= timer_d;
      combo_q <= (timer_d != '0);
    end
  end

  assign score        = {24'd0, score_q};
  assign score_tens   = tens_q;
  assign score_ones   = ones_q;
  assign saturated    = sat_q;
  assign combo_active = combo_q;
  assign playing      = in_play;

`ifdef SCORE_HIGH_SCORE_EN
  logic [7:0] high_q;
  logic       record_q;

  // Compared at the PLAY->OVER edge using the score held going into that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_q   <= 8'd0;
      record_q <= 1'b0;
    end else if (new_game) begin
      record_q <= 1'b0;
    end else if (in_play && game_over && (score_q > high_q)) begin
      high_q   <= score_q;
      record_q <= 1'b1;
    end
  end

  assign high_score = {24'd0, high_q};
  assign new_record = record_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - table-driven and sequence checks for score_keeper
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst, new_game, game_over, enemy_hit, boss_hit;
  logic [31:0] score;
  logic [3:0]  score_tens, score_ones;
  logic        saturated, combo_active, playing;
`ifdef SCORE_HIGH_SCORE_EN
  logic [31:0] high_score;
  logic        new_record;
`endif

  score_keeper #(
    .SCORE_MAX(99), .ENEMY_PTS(1), .BOSS_PTS(5), .COMBO_WINDOW(8), .TIMER_W(26)
  ) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .game_over(game_over),
    .enemy_hit(enemy_hit), .boss_hit(boss_hit),
    .score(score), .score_tens(score_tens), .score_ones(score_ones),
    .saturated(saturated), .combo_active(combo_active), .playing(playing)
`ifdef SCORE_HIGH_SCORE_EN
    , .high_score(high_score), .new_record(new_record)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic  ng, go, e, b;
    int    cyc;
    int    score;
    logic  sat, play, combo;
    string name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_score(input string tag, input int exp, input logic sat);
    check({tag, ".score"}, score, 32'(exp));
    check({tag, ".tens"}, 32'(score_tens), 32'(exp / 10));
    check({tag, ".ones"}, 32'(score_ones), 32'(exp % 10));
    check({tag, ".sat"}, 32'(saturated), 32'(sat));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic e, input logic b);
    enemy_hit = e;
    boss_hit  = b;
    tick(1);
    enemy_hit = 1'b0;
    boss_hit  = 1'b0;
    tick(1);
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; game_over = 1'b0; enemy_hit = 1'b0; boss_hit = 1'b0;
    tick(3);
    rst = 1'b0;
    check_score("reset", 0, 1'b0);
    check("reset.playing", 32'(playing), 32'd0);
    check("reset.combo", 32'(combo_active), 32'd0);

    for (int i = 0; i < 10; i++) begin
      enemy_hit = i[0];
      boss_hit  = i[0];
      tick(1);
    end
    enemy_hit = 1'b0;
    boss_hit  = 1'b0;
    check_score("idle", 0, 1'b0);
    check("idle.playing", 32'(playing), 32'd0);

    //               ng go e  b  cyc score sat play combo
    tbl.push_back('{1, 0, 0, 0, 1,  0,  0, 1, 0, "start"});
    tbl.push_back('{0, 0, 1, 0, 1,  1,  0, 1, 1, "first_hit"});
    tbl.push_back('{0, 0, 1, 0, 19, 1,  0, 1, 0, "hold_high"});
    tbl.push_back('{0, 0, 0, 0, 1,  1,  0, 1, 0, "release"});
    tbl.push_back('{0, 0, 1, 0, 1,  2,  0, 1, 1, "edge_a"});
    tbl.push_back('{0, 0, 0, 0, 4,  2,  0, 1, 1, "gap"});
    tbl.push_back('{0, 0, 1, 0, 1,  4,  0, 1, 1, "combo_x2"});
    tbl.push_back('{0, 0, 0, 0, 19, 4,  0, 1, 0, "expire"});
    tbl.push_back('{0, 0, 1, 0, 1,  5,  0, 1, 1, "no_double"});
    tbl.push_back('{0, 0, 0, 0, 10, 5,  0, 1, 0, "expire2"});
    tbl.push_back('{0, 0, 1, 1, 1,  11, 0, 1, 1, "both"});
    tbl.push_back('{0, 0, 0, 0, 10, 11, 0, 1, 0, "expire3"});
    tbl.push_back('{0, 1, 0, 0, 1,  11, 0, 0, 0, "game_over"});
    tbl.push_back('{0, 0, 1, 1, 1,  11, 0, 0, 0, "over_ignore"});
    tbl.push_back('{1, 1, 0, 0, 1,  0,  0, 1, 0, "ng_priority"});
    tbl.push_back('{0, 0, 1, 0, 1,  1,  0, 1, 1, "replay_hit"});
    tbl.push_back('{0, 0, 0, 0, 10, 1,  0, 1, 0, "expire4"});

    foreach (tbl[k]) begin
      new_game  = tbl[k].ng;
      game_over = tbl[k].go;
      enemy_hit = tbl[k].e;
      boss_hit  = tbl[k].b;
      tick(tbl[k].cyc);
      check_score(tbl[k].name, tbl[k].score, tbl[k].sat);
      check({tbl[k].name, ".playing"}, 32'(playing), 32'(tbl[k].play));
      check({tbl[k].name, ".combo"}, 32'(combo_active), 32'(tbl[k].combo));
    end
    new_game = 1'b0; game_over = 1'b0; enemy_hit = 1'b0; boss_hit = 1'b0;
    tick(1);

    // Saturation: 5 + 9*10 = 95, then +1, +1, then boss clips at 99.
    start_game();
    check_score("sat.start", 0, 1'b0);
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1);
    check_score("sat.95", 95, 1'b0);
    tick(10);
    pulse(1'b1, 1'b0);
    check_score("sat.96", 96, 1'b0);
    tick(10);
    pulse(1'b1, 1'b0);
    check_score("sat.97", 97, 1'b0);
    tick(10);
    pulse(1'b0, 1'b1);
    check_score("sat.clip", 99, 1'b1);
    pulse(1'b1, 1'b0);
    check_score("sat.hold", 99, 1'b1);
    start_game();
    check_score("sat.newgame", 0, 1'b0);

    // Game over at 12 freezes the score.
    pulse(1'b1, 1'b1);
    tick(10);
    pulse(1'b1, 1'b1);
    check_score("go.12", 12, 1'b0);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    check("go.playing", 32'(playing), 32'd0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check_score("go.frozen", 12, 1'b0);
`ifdef SCORE_HIGH_SCORE_EN
    check("hs.first", high_score, 32'd12);
    check("hs.record", 32'(new_record), 32'd1);
`endif
    start_game();
    check("go.replay", 32'(playing), 32'd1);
    pulse(1'b0, 1'b1);
    tick(10);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    check_score("go.5", 5, 1'b0);
`ifdef SCORE_HIGH_SCORE_EN
    check("hs.keep", high_score, 32'd12);
    check("hs.no_record", 32'(new_record), 32'd0);
`endif

    // Reset mid-game.
    start_game();
    pulse(1'b1, 1'b1);
    check_score("rst.pre", 6, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_score("rst.post", 0, 1'b0);
    check("rst.playing", 32'(playing), 32'd0);
    check("rst.combo", 32'(combo_active), 32'd0);
`ifdef SCORE_HIGH_SCORE_EN
    check("rst.hs", high_score, 32'd0);
    check("rst.record", 32'(new_record), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side score accumulator for Raiden.
- Takes collision hit events (enemy and boss kills) and the game-flow controls (new game, game over).
- Keeps a saturating 0..99 score with a combo bonus.
- Its `score` output drives the 7-segment score decoder directly; registered BCD digits are also provided for other consumers (VGA HUD).

Parameters:
- SCORE_MAX, 99, saturation ceiling. Must be ≤ 99.
- ENEMY_PTS, 1, base points per enemy kill.
- BOSS_PTS, 5, base points per boss kill.
- COMBO_WINDOW, 50_000_000, cycles after a kill during which the next kill scores double.
- TIMER_W, 26, width of the combo timer. Must hold COMBO_WINDOW.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- new_game  in  1  level; when high, clears score and enters PLAY
- game_over  in  1  level; when high during PLAY, ends the game
- enemy_hit  in  1  level from collision logic; may stay high for many cycles
- boss_hit  in  1  level from collision logic; may stay high for many cycles
- score  out  32  binary score 0..SCORE_MAX, zero-extended; feeds the 7-seg decoder
- score_tens  out  4  BCD tens digit of score
- score_ones  out  4  BCD ones digit of score
- saturated  out  1  sticky; set when an addition clipped at SCORE_MAX
- combo_active  out  1  high while the combo timer is non-zero
- playing  out  1  high in PLAY state

Behaviour:
- Reset: state=IDLE. All outputs 0. Hit history registers and combo timer are 0.
- States:
  - IDLE → PLAY on new_game.
  - PLAY → OVER on game_over (only when new_game is low).
  - OVER → PLAY on new_game.
  - new_game has priority over game_over in every state.
- Entering PLAY: on the same edge, score, BCD digits, saturated and combo timer are cleared to 0.
- Hit detection:
  - enemy_hit and boss_hit are each edge-detected against a 1-cycle history register.
  - Only 0→1 transitions count.
  - Edges are counted only in PLAY and are ignored in IDLE and OVER. History registers still update in every state.
- Points per edge:
  - add = (enemy_edge ? ENEMY_PTS : 0) + (boss_edge ? BOSS_PTS : 0).
  - Simultaneous enemy and boss edges on one cycle sum.
  - If combo timer ≠ 0 when the edge is detected, add is doubled.
- Update latency: score, score_tens and score_ones update on the same clock edge at which the rising input level is first sampled high, i.e. 1 cycle after the input rises.
- Saturation:
  - next = score + add, computed 8 bits wide.
  - If next > SCORE_MAX, score = SCORE_MAX and saturated is set to 1.
  - saturated is cleared only by rst or by entering PLAY.
- Combo timer:
  - Loads COMBO_WINDOW−1 on any counted hit edge.
  - Otherwise decrements to 0 while in PLAY.
  - Forced to 0 in IDLE and OVER.
  - combo_active = (timer ≠ 0), registered.
- BCD: tens and ones are always consistent with score on the same cycle; they are never one cycle stale.
- OVER: score is frozen.
- playing = (state == PLAY).
- rst asserted mid-game overrides everything and returns to IDLE with score 0.

Optional Feature:
- Macro: SCORE_HIGH_SCORE_EN.
- Defined:
  - Adds outputs `high_score` (32, binary) and `new_record` (1).
  - On the PLAY→OVER edge, if score > high_score, high_score takes score and new_record is set to 1.
  - new_record clears on entering PLAY.
  - high_score survives new_game and is cleared only by rst.
- Undefined: both ports and all associated logic are absent.

Test Plan:
- Reset, then idle 10 cycles → score=0, tens=0, ones=0, saturated=0, playing=0.
- Pulse new_game, then raise enemy_hit and hold 20 cycles → score=1 exactly once, 1 cycle after the rise; combo_active=1.
- In PLAY, enemy edge, then a second enemy edge 5 cycles later (COMBO_WINDOW=8 for sim) → score 1 then 3. A third edge 20 cycles later → score 4, not doubled.
- Enemy and boss rise on the same cycle with no combo → score increases by 6.
- Score at 97, boss edge → score=99, tens=9, ones=9, saturated=1; a further enemy edge keeps 99. new_game → score=0, saturated=0.
- game_over at score 12, then hit edges → score stays 12. With SCORE_HIGH_SCORE_EN defined: high_score=12 and new_record=1. A next game ending at 5 → high_score stays 12, new_record=0. rst mid-game → all outputs 0, including high_score.
